// File: rtl/lfsr_pattern_ctrl_if.sv
// lfsr_pattern_ctrl_if: command, LFSR-side and UART-TX-side signals of the pattern sequencer.
interface lfsr_pattern_ctrl_if #(
    parameter int LFSR_BITS = 9,
    parameter int LEN_W     = 16
);
    logic                 cmd_start;
    logic                 cmd_stop;
    logic [LFSR_BITS-1:0] cmd_seed;
    logic [LEN_W-1:0]     cmd_len;
    logic                 lfsr_enb;
    logic                 lfsr_seed_dv;
    logic [LFSR_BITS-1:0] lfsr_seed_data;
    logic [LFSR_BITS-1:0] lfsr_data;
    logic                 lfsr_done;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 done;
    logic                 seed_err;
    logic [7:0]           wrap_cnt;

    modport master (
        output cmd_start, cmd_stop, cmd_seed, cmd_len, lfsr_data, lfsr_done, tx_ready,
        input  lfsr_enb, lfsr_seed_dv, lfsr_seed_data, tx_data, tx_valid, busy, done, seed_err, wrap_cnt
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_seed, cmd_len, lfsr_data, lfsr_done, tx_ready,
        output lfsr_enb, lfsr_seed_dv, lfsr_seed_data, tx_data, tx_valid, busy, done, seed_err, wrap_cnt
    );
endinterface

// File: rtl/lfsr_pattern_ctrl.sv
// lfsr_pattern_ctrl: seeds and steps an external XNOR(9,5) LFSR, emitting one byte per
// STEPS_PER_BYTE advances over a valid/ready handshake, and counts sequence wraps.
module lfsr_pattern_ctrl #(
    parameter int LFSR_BITS      = 9,
    parameter int STEPS_PER_BYTE = 8,
    parameter int LEN_W          = 16
) (
    input logic clk,
    input logic reset_n,
    lfsr_pattern_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SEED, S_STEP, S_PRESENT, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [LFSR_BITS-1:0] r_seed;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_byte_cnt;
    logic [7:0]           r_step_cnt;
    logic [7:0]           r_wrap_cnt;
    logic                 r_seed_err;

    // All-ones is the XNOR lock-up state and can never be used as a seed.
    logic w_bad_seed, w_start_ok, w_hs, w_last_step;
    logic [LEN_W-1:0] w_byte_nxt;
    assign w_bad_seed  = bus.cmd_seed == '1;
    assign w_start_ok  = (r_state == S_IDLE) && bus.cmd_start && !w_bad_seed;
    assign w_hs        = (r_state == S_PRESENT) && bus.tx_ready;
    assign w_last_step = r_step_cnt == 8'(STEPS_PER_BYTE - 1);
    assign w_byte_nxt  = r_byte_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_start_ok ? S_SEED : S_IDLE;
            S_SEED:    w_next = S_STEP;
            S_STEP:    w_next = w_last_step ? S_PRESENT : S_STEP;
            S_PRESENT: w_next = !bus.tx_ready ? S_PRESENT :
                                (r_len != '0 && w_byte_nxt == r_len) ? S_DONE : S_STEP;
            default:   w_next = S_IDLE;
        endcase
        if (bus.cmd_stop && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seed     <= '0;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_step_cnt <= '0;
            r_wrap_cnt <= '0;
            r_seed_err <= 1'b0;
        end else begin
            r_seed_err <= (r_state == S_IDLE) && bus.cmd_start && w_bad_seed;
            r_step_cnt <= (r_state == S_STEP) ? r_step_cnt + 8'd1 : 8'd0;
            if (w_start_ok) begin
                r_seed     <= bus.cmd_seed;
                r_len      <= bus.cmd_len;
                r_byte_cnt <= '0;
                r_wrap_cnt <= '0;
            end
            if (w_hs) r_byte_cnt <= w_byte_nxt;
            // The LFSR only advances in STEP, so only there does lfsr_done mean a wrap.
            if (r_state == S_STEP && bus.lfsr_done && r_wrap_cnt != 8'hFF) r_wrap_cnt <= r_wrap_cnt + 8'd1;
        end
    end

    assign bus.lfsr_enb       = (r_state == S_SEED) || (r_state == S_STEP);
    assign bus.lfsr_seed_dv   = r_state == S_SEED;
    assign bus.lfsr_seed_data = r_seed;
    assign bus.tx_valid       = r_state == S_PRESENT;
    assign bus.tx_data        = (r_state == S_PRESENT) ? bus.lfsr_data[7:0] : 8'h00;
    assign bus.busy           = r_state != S_IDLE;
    assign bus.done           = r_state == S_DONE;
    assign bus.seed_err       = r_seed_err;
    assign bus.wrap_cnt       = r_wrap_cnt;
endmodule
